// File: rtl/seq_hit_tally.sv
// Tally for sequence-detector hits: two-digit BCD count with sticky overflow,
// LED pulse stretcher and inter-hit gap measurement, all registered.
module seq_hit_tally #(
   parameter int unsigned STRETCH = 24,
   parameter int unsigned GAP_W   = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             hit,
   input  logic             en,
   output logic [3:0]       bcd_ones,
   output logic [3:0]       bcd_tens,
   output logic             ovf,
   output logic             led,
   output logic [GAP_W-1:0] gap,
   output logic             gap_vld
);

   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [23:0]      RELOAD  = 24'(STRETCH - 1);
   localparam logic [GAP_W-1:0] GAP_MAX = '1;

   state_t           state_q, state_d;
   logic [23:0]      timer_q, timer_d;
   logic             led_q, led_d;
   logic [3:0]       ones_q, ones_d;
   logic [3:0]       tens_q, tens_d;
   logic             ovf_q, ovf_d;
   logic [GAP_W-1:0] run_q, run_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             gap_vld_q, gap_vld_d;
   logic             seen_q, seen_d;
   logic             counted;

   function automatic logic [GAP_W-1:0] sat_inc(input logic [GAP_W-1:0] x);
      return (x == GAP_MAX) ? x : x + 1'b1;
   endfunction

   assign counted = hit & en;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      led_d     = led_q;
      ones_d    = ones_q;
      tens_d    = tens_q;
      ovf_d     = ovf_q;
      run_d     = run_q;
      gap_d     = gap_q;
      gap_vld_d = gap_vld_q;
      seen_d    = seen_q;

      if (counted) begin
         if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            if (tens_q == 4'd9) begin
               tens_d = 4'd0;
               ovf_d  = 1'b1;
            end else begin
               tens_d = tens_q + 4'd1;
            end
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end

      // Stretcher keeps decaying even while en=0; only counted hits reload it.
      case (state_q)
         IDLE: begin
            if (counted) begin
               state_d = HOLD;
               timer_d = RELOAD;
               led_d   = 1'b1;
            end
         end
         HOLD: begin
            if (counted) begin
               timer_d = RELOAD;
            end else if (timer_q != 24'd0) begin
               timer_d = timer_q - 24'd1;
            end else begin
               state_d = IDLE;
               led_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            led_d   = 1'b0;
         end
      endcase

      // Captured gap is the running count plus the hit cycle itself.
      if (counted) begin
         if (seen_q) begin
            gap_d     = sat_inc(run_q);
            gap_vld_d = 1'b1;
         end
         seen_d = 1'b1;
         run_d  = '0;
      end else if (en) begin
         run_d = sat_inc(run_q);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         led_q     <= 1'b0;
         ones_q    <= 4'd0;
         tens_q    <= 4'd0;
         ovf_q     <= 1'b0;
         run_q     <= '0;
         gap_q     <= '0;
         gap_vld_q <= 1'b0;
         seen_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         led_q     <= led_d;
         ones_q    <= ones_d;
         tens_q    <= tens_d;
         ovf_q     <= ovf_d;
         run_q     <= run_d;
         gap_q     <= gap_d;
         gap_vld_q <= gap_vld_d;
         seen_q    <= seen_d;
      end
   end

   assign bcd_ones = ones_q;
   assign bcd_tens = tens_q;
   assign ovf      = ovf_q;
   assign led      = led_q;
   assign gap      = gap_q;
   assign gap_vld  = gap_vld_q;

endmodule

// File: doc/seq_hit_tally.md
Name: seq_hit_tally

Overview:
- Downstream consumer of the serial sequence detector's one-cycle match output.
- Counts detections as a two-digit BCD tally that wraps 99->00 and sets a sticky overflow flag on wrap.
- Stretches each detection into a visible LED pulse.
- Measures the clock-cycle gap between consecutive detections.
- Runs on the detector's clock and clear, so both blocks reset in the same cycle.

Parameters:
- STRETCH, 24, LED hold length in clk cycles after the last detection; legal range 1..2^24-1.
- GAP_W, 8, width of the inter-detection gap counter; saturates at all-ones.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- clr  in  1  synchronous active-high reset; overrides every other input.
- hit  in  1  detection strobe from the sequence detector; every cycle hit=1 counts as one detection.
- en  in  1  tally enable; when 0, hits are ignored by the tally, led and gap logic.
- bcd_ones  out  4  units digit of the tally, 0..9.
- bcd_tens  out  4  tens digit of the tally, 0..9.
- ovf  out  1  sticky; set when the tally wraps 99->00.
- led  out  1  high while the stretcher is in HOLD.
- gap  out  GAP_W  cycles from the previous counted hit to the latest counted hit.
- gap_vld  out  1  high once at least two hits have been counted since clr.

Behaviour:
- Reset (clr=1 at an edge): bcd_ones=0, bcd_tens=0, ovf=0, led=0, gap=0, gap_vld=0, stretch timer=0, running gap counter=0, seen_one=0, stretcher state=IDLE. clr wins over a simultaneous hit.
- Counted hit: hit=1 and en=1 at an edge; all effects below apply at that same edge.
- Effects are registered: a counted hit at edge N appears on the outputs after edge N. Latency is one cycle, with no combinational path from hit to any output.
- BCD tally:
  - ones increments by 1.
  - When ones=9, ones becomes 0 and tens increments.
  - When tens=9 and ones=9, both become 0 and ovf is set to 1.
  - ovf is cleared only by clr.
  - Digits never hold values 10..15.
- Stretcher FSM, two states:
  - IDLE: a counted hit goes to HOLD with timer=STRETCH-1 and led=1.
  - HOLD: a counted hit reloads timer=STRETCH-1, so back-to-back hits extend the pulse.
  - HOLD with no hit and timer>0: timer decrements.
  - HOLD with no hit and timer=0: returns to IDLE with led=0.
  - led is high for exactly STRETCH cycles after an isolated hit.
- Gap measurement:
  - The running counter increments every cycle in which en=1 and no counted hit occurs. It saturates at 2^GAP_W-1 and does not wrap.
  - On a counted hit with seen_one=1: gap captures running+1 (the cycle distance between the two hits, saturated at 2^GAP_W-1) and gap_vld is set to 1.
  - On the first counted hit (seen_one=0): seen_one is set and gap is unchanged.
  - Every counted hit clears the running counter to 0.
  - While en=0 the running counter holds, and all registers hold except the stretch timer and led, which continue to decay.
- Consecutive-cycle hits are legal: each cycle counts, and gap=1.

Test Plan:
- clr=1 for 2 cycles, then idle 10 cycles with en=1 -> all outputs 0, led=0, gap_vld=0.
- en=1, single hit at cycle 5 -> the cycle after edge 5: ones=1 and led rises; led stays high for exactly STRETCH cycles; gap_vld stays 0.
- en=1, hits at cycles 10, 14 and 15 -> gap=4 after the second hit and gap=1 after the third; ones=3; gap_vld=1; led remains continuously high until STRETCH cycles after cycle 15.
- 100 hits spaced 3 cycles apart -> after the 99th: tens=9, ones=9, ovf=0; after the 100th: tens=0, ones=0, ovf=1; ovf still 1 after 5 more hits.
- GAP_W=8, hits 300 cycles apart -> gap=255 (saturated); en=0 with hit pulsed -> no change to digits, gap or led.
- clr and hit high in the same cycle mid-HOLD -> the next cycle has all outputs 0 and state IDLE; a hit 3 cycles later gives ones=1 and gap_vld=0.
